// File: rtl/pll_ctrl_pkg.sv
// Shared state encoding and default timing constants for the PLL bring-up controller.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    StRstPll    = 3'd0,
    StWaitLock  = 3'd1,
    StStabilize = 3'd2,
    StRun       = 3'd3,
    StFail      = 3'd4
  } pll_state_e;

  localparam int unsigned DefRstPulseCycles    = 16;
  localparam int unsigned DefLockTimeoutCycles = 50_000;
  localparam int unsigned DefStableCycles      = 1024;
  localparam int unsigned DefMaxRetries        = 7;

  // Dwell counter width: wide enough for the longest per-state wait, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; flops clear on reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_ctrl.sv
// PLL bring-up sequencer: pulses PLL reset, waits for a stable lock, retries on
// failure and tracks lock losses while running.
module pll_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = DefRstPulseCycles,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DefLockTimeoutCycles,
  parameter int unsigned STABLE_CYCLES       = DefStableCycles,
  parameter int unsigned MAX_RETRIES         = DefMaxRetries
) (
  input  logic       extClk50,
  input  logic       extRst,
  input  logic       pllLocked,
  input  logic       restart,
  output logic       pllRst,
  output logic       sysRstReq,
  output logic       ready,
  output logic       fail,
  output logic [2:0] retries,
  output logic [7:0] lossCount
);

  localparam int unsigned CntW = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                           STABLE_CYCLES);
  localparam logic [CntW-1:0] RstLast    = CntW'(RST_PULSE_CYCLES - 1);
  localparam logic [CntW-1:0] LockLast   = CntW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] StableLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [2:0]      RetryLimit = 3'(MAX_RETRIES);

  logic            w_lock_s;
  pll_state_e      r_state;
  pll_state_e      w_state_d;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;
  logic [2:0]      r_retries;
  logic [2:0]      w_retries_d;
  logic [2:0]      w_retries_inc;
  logic            w_budget_gone;
  logic [7:0]      r_loss_count;
  logic [7:0]      w_loss_d;
  logic            w_entry;
  logic            w_counting;
  logic            r_pll_rst;
  logic            r_sys_rst_req;
  logic            r_ready;
  logic            r_fail;

  sync_2ff #(
    .WIDTH(1)
  ) u_lock_sync (
    .i_clk(extClk50),
    .i_rst(extRst),
    .i_d  (pllLocked),
    .o_q  (w_lock_s)
  );

  assign w_retries_inc = r_retries + 3'd1;
  assign w_budget_gone = (w_retries_inc == RetryLimit);

  always_comb begin
    w_state_d   = r_state;
    w_retries_d = r_retries;
    w_loss_d    = r_loss_count;
    if (restart) begin
      // Restart overrides every other transition, including a lock loss in RUN.
      w_state_d   = StRstPll;
      w_retries_d = '0;
    end else begin
      unique case (r_state)
        StRstPll: begin
          if (r_cnt == RstLast) w_state_d = StWaitLock;
        end
        StWaitLock: begin
          if (w_lock_s) begin
            w_state_d = StStabilize;
          end else if (r_cnt == LockLast) begin
            w_retries_d = w_retries_inc;
            w_state_d   = w_budget_gone ? StFail : StRstPll;
          end
        end
        StStabilize: begin
          if (!w_lock_s) begin
            w_retries_d = w_retries_inc;
            w_state_d   = w_budget_gone ? StFail : StRstPll;
          end else if (r_cnt == StableLast) begin
            w_retries_d = '0;
            w_state_d   = StRun;
          end
        end
        StRun: begin
          if (!w_lock_s) begin
            w_state_d = StRstPll;
            w_loss_d  = (r_loss_count == 8'hFF) ? r_loss_count : r_loss_count + 8'd1;
          end
        end
        StFail: w_state_d = StFail;
        default: w_state_d = StRstPll;
      endcase
    end
  end

  // Only the timed states advance the counter; RUN and FAIL hold it so it never wraps.
  assign w_entry    = restart || (w_state_d != r_state);
  assign w_counting = (r_state == StRstPll) || (r_state == StWaitLock) ||
                      (r_state == StStabilize);
  assign w_cnt_d    = w_entry    ? '0 :
                      w_counting ? r_cnt + CntW'(1) : r_cnt;

  always_ff @(posedge extClk50 or posedge extRst) begin
    if (extRst) begin
      r_state       <= StRstPll;
      r_cnt         <= '0;
      r_retries     <= '0;
      r_loss_count  <= '0;
      r_pll_rst     <= 1'b1;
      r_sys_rst_req <= 1'b1;
      r_ready       <= 1'b0;
      r_fail        <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_cnt         <= w_cnt_d;
      r_retries     <= w_retries_d;
      r_loss_count  <= w_loss_d;
      r_pll_rst     <= (w_state_d == StRstPll) || (w_state_d == StFail);
      r_sys_rst_req <= (w_state_d != StRun);
      r_ready       <= (w_state_d == StRun);
      r_fail        <= (w_state_d == StFail);
    end
  end

  assign pllRst    = r_pll_rst;
  assign sysRstReq = r_sys_rst_req;
  assign ready     = r_ready;
  assign fail      = r_fail;
  assign retries   = r_retries;
  assign lossCount = r_loss_count;

  ready_fail_excl_a: assert property (@(posedge extClk50) disable iff (extRst)
    !(r_ready && r_fail));
  sys_rst_req_a: assert property (@(posedge extClk50) disable iff (extRst)
    r_sys_rst_req == !r_ready);

endmodule

// File: tb/tb_pll_ctrl.sv
// Bench for pll_ctrl: directed vector table, corner sequences, then random stimulus
// cross-checked every cycle against a phase-level reference model.
module tb_pll_ctrl;

  localparam int RstN    = 4;
  localparam int LockN   = 32;
  localparam int StableN = 8;
  localparam int MaxR    = 2;
  localparam int RstOuts = (1 << 14) | (1 << 13);

  localparam int PhReset  = 0;
  localparam int PhWait   = 1;
  localparam int PhSettle = 2;
  localparam int PhRun    = 3;
  localparam int PhDead   = 4;

  typedef struct {
    int phase;
    int elapsed;
    int fails;
    int losses;
    bit s1;
    bit s2;
  } model_t;

  typedef struct {
    int lock;
    int req;
    int n;
    int pll;
    int sys;
    int rdy;
    int flt;
    int ret;
    int loss;
  } vec_t;

  logic        extClk50  = 1'b0;
  logic        extRst    = 1'b1;
  logic        pllLocked = 1'b0;
  logic        restart   = 1'b0;
  logic        pllRst;
  logic        sysRstReq;
  logic        ready;
  logic        fail;
  logic [2:0]  retries;
  logic [7:0]  lossCount;
  logic [14:0] dut_outs;

  int     checks   = 0;
  int     failures = 0;
  bit     model_en = 1'b0;
  model_t m;

  pll_ctrl #(
    .RST_PULSE_CYCLES   (RstN),
    .LOCK_TIMEOUT_CYCLES(LockN),
    .STABLE_CYCLES      (StableN),
    .MAX_RETRIES        (MaxR)
  ) dut (
    .extClk50 (extClk50),
    .extRst   (extRst),
    .pllLocked(pllLocked),
    .restart  (restart),
    .pllRst   (pllRst),
    .sysRstReq(sysRstReq),
    .ready    (ready),
    .fail     (fail),
    .retries  (retries),
    .lossCount(lossCount)
  );

  always #5 extClk50 = ~extClk50;

  assign dut_outs = {pllRst, sysRstReq, ready, fail, retries, lossCount};

  function automatic model_t model_reset();
    model_t r;
    r.phase   = PhReset;
    r.elapsed = 0;
    r.fails   = 0;
    r.losses  = 0;
    r.s1      = 1'b0;
    r.s2      = 1'b0;
    return r;
  endfunction

  // One clock of the bring-up rules; decisions use the lock value already two flops deep.
  function automatic model_t model_next(input model_t c, input bit lock_in, input bit req);
    model_t n = c;
    bit locked = c.s2;
    int done = c.elapsed + 1;
    n.s1 = lock_in;
    n.s2 = c.s1;
    n.elapsed = done;
    if (req) begin
      n.phase = PhReset;
      n.elapsed = 0;
      n.fails = 0;
    end else begin
      case (c.phase)
        PhReset: if (done == RstN) begin
          n.phase = PhWait;
          n.elapsed = 0;
        end
        PhWait: begin
          if (locked) begin
            n.phase = PhSettle;
            n.elapsed = 0;
          end else if (done == LockN) begin
            n.fails = c.fails + 1;
            n.phase = (n.fails >= MaxR) ? PhDead : PhReset;
            n.elapsed = 0;
          end
        end
        PhSettle: begin
          if (!locked) begin
            n.fails = c.fails + 1;
            n.phase = (n.fails >= MaxR) ? PhDead : PhReset;
            n.elapsed = 0;
          end else if (done == StableN) begin
            n.phase = PhRun;
            n.fails = 0;
            n.elapsed = 0;
          end
        end
        PhRun: begin
          if (!locked) begin
            n.losses = (c.losses < 255) ? c.losses + 1 : 255;
            n.phase = PhReset;
            n.elapsed = 0;
          end
        end
        default: n.phase = c.phase;
      endcase
    end
    return n;
  endfunction

  function automatic logic [14:0] model_outs(input model_t c);
    logic rdy;
    logic dead;
    rdy  = (c.phase == PhRun);
    dead = (c.phase == PhDead);
    return {(c.phase == PhReset) || dead, !rdy, rdy, dead, 3'(c.fails), 8'(c.losses)};
  endfunction

  always @(posedge extClk50 or posedge extRst) begin
    if (extRst) m <= model_reset();
    else        m <= model_next(m, pllLocked, restart);
  end

  function automatic int pack_exp(input vec_t v);
    return (v.pll << 14) | (v.sys << 13) | (v.rdy << 12) | (v.flt << 11) | (v.ret << 8) |
           v.loss;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_le(input string name, input int act, input int lim);
    checks++;
    if (act > lim) begin
      failures++;
      $display("FAIL %s: got %0d, required at most %0d", name, act, lim);
    end
  endtask

  // Advance one clock and sample on the falling edge against the reference model.
  task automatic step();
    @(posedge extClk50);
    @(negedge extClk50);
    if (model_en) begin
      checks++;
      if (dut_outs !== model_outs(m)) begin
        failures++;
        $display("FAIL model t=%0t: got %h, expected %h", $time, dut_outs, model_outs(m));
      end
    end
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0:       return ready;
      1:       return pllRst;
      2:       return sysRstReq;
      default: return !pllRst;
    endcase
  endfunction

  task automatic wait_until(input string name, input int sel, input int limit,
                            output int cycles);
    cycles = 0;
    while (!cond(sel) && cycles < limit) begin
      step();
      cycles++;
    end
    checks++;
    if (!cond(sel)) begin
      failures++;
      $display("FAIL %s: got no event after %0d cycles, required within %0d", name, cycles,
               limit);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[13];
    int cyc;
    int hi;
    int loss_exp;
    int run_left;

    tbl[0]  = '{0, 0, 3,  1, 1, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 10, 0, 1, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 10, 0, 1, 0, 0, 0, 0};
    tbl[3]  = '{1, 0, 3,  0, 0, 1, 0, 0, 0};
    tbl[4]  = '{0, 0, 2,  0, 0, 1, 0, 0, 0};
    tbl[5]  = '{0, 0, 4,  1, 1, 0, 0, 0, 1};
    tbl[6]  = '{0, 0, 32, 0, 1, 0, 0, 0, 1};
    tbl[7]  = '{0, 0, 4,  1, 1, 0, 0, 1, 1};
    tbl[8]  = '{0, 0, 32, 0, 1, 0, 0, 1, 1};
    tbl[9]  = '{0, 0, 5,  1, 1, 0, 1, 2, 1};
    tbl[10] = '{0, 1, 1,  1, 1, 0, 0, 0, 1};
    tbl[11] = '{0, 0, 3,  1, 1, 0, 0, 0, 1};
    tbl[12] = '{0, 0, 1,  0, 1, 0, 0, 0, 1};

    repeat (3) @(negedge extClk50);
    check("reset_outs", int'(dut_outs), RstOuts);
    model_en = 1'b1;
    extRst = 1'b0;

    for (int r = 0; r < 13; r++) begin
      pllLocked = (tbl[r].lock != 0);
      restart   = (tbl[r].req != 0);
      for (int k = 0; k < tbl[r].n; k++) begin
        step();
        check($sformatf("vec%0d_cyc%0d", r, k), int'(dut_outs), pack_exp(tbl[r]));
      end
    end
    restart = 1'b0;

    // Short lock glitch inside the stabilize window.
    pllLocked = 1'b1;
    repeat (5) step();
    check("glitch_pre_ready", int'(ready), 0);
    pllLocked = 1'b0;
    repeat (3) step();
    pllLocked = 1'b1;
    check("glitch_retries", int'(retries), 1);
    hi = 0;
    while (pllRst && hi < 20) begin
      hi++;
      step();
    end
    check("glitch_pllrst_width", hi, RstN);
    wait_until("glitch_ready", 0, 100, cyc);
    check("glitch_retries_clr", int'(retries), 0);

    loss_exp = 1;
    for (int d = 0; d < 3; d++) begin
      pllLocked = 1'b0;
      wait_until($sformatf("drop%0d_sysrst", d), 2, 10, cyc);
      check_le($sformatf("drop%0d_latency", d), cyc, 3);
      loss_exp++;
      check($sformatf("drop%0d_loss", d), int'(lossCount), loss_exp);
      pllLocked = 1'b1;
      wait_until($sformatf("drop%0d_ready", d), 0, 100, cyc);
    end

    // Restart lands on the same edge that sees the lock loss.
    pllLocked = 1'b0;
    step();
    step();
    check("r35_still_ready", int'(ready), 1);
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("r35_pllrst", int'(pllRst), 1);
    check("r35_ready", int'(ready), 0);
    check("r35_loss", int'(lossCount), loss_exp);

    wait_until("r35_wait_lock", 3, 10, cyc);
    repeat (40) step();
    check("pre_async_retries", int'(retries), 1);
    #2 extRst = 1'b1;
    #1;
    check("async_rst_outs", int'(dut_outs), RstOuts);
    @(negedge extClk50);
    extRst = 1'b0;

    pllLocked = 1'b1;
    wait_until("rebring_ready", 0, 100, cyc);
    check("rebring_loss", int'(lossCount), 0);
    for (int d = 0; d < 256; d++) begin
      pllLocked = 1'b0;
      wait_until("sat_sysrst", 2, 10, cyc);
      pllLocked = 1'b1;
      wait_until("sat_ready", 0, 40, cyc);
    end
    check("loss_saturated", int'(lossCount), 255);

    run_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (run_left == 0) begin
        pllLocked = ($urandom_range(0, 3) != 0);
        run_left  = $urandom_range(1, 60);
      end
      run_left--;
      restart = ($urandom_range(0, 249) == 0);
      extRst  = ($urandom_range(0, 1499) == 0);
      step();
    end
    restart = 1'b0;
    extRst  = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
